// File: rtl/softex_stream_tracker.sv
// softex_stream_tracker
// Tracks one load job on the stream between the streamer and the datapath:
// counts accepted beats against the job length, buffers beats in a 2-entry
// FIFO, and tags each beat with a per-lane valid mask and a last flag.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear_i           synchronous soft clear (same effect as rst_i)
//   enable_i          low freezes all state and blocks both handshakes
//   start_i, length_i one-cycle job start with length in elements
//   in_valid_i/in_ready_o/in_data_i        upstream beat stream
//   out_valid_o/out_ready_i/out_data_o     downstream beat stream
//   out_mask_o        per-lane valid mask of the current output beat
//   out_last_o        final beat of the job
//   busy_o            job in progress (state other than IDLE)
//   done_o            one-cycle end-of-job pulse
module softex_stream_tracker #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ELEM_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             enable_i,
    input  logic                             start_i,
    input  logic [LEN_WIDTH-1:0]             length_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [DATA_WIDTH-1:0]            in_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic [DATA_WIDTH/ELEM_WIDTH-1:0] out_mask_o,
    output logic                             out_last_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int unsigned N_ELEM = DATA_WIDTH / ELEM_WIDTH;
    localparam int unsigned TAIL_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] total_beats;
    logic [LEN_WIDTH-1:0] accepted_beats;
    logic [TAIL_W-1:0]    tail;

    // 2-entry FIFO storage
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [N_ELEM-1:0]     fifo_mask [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic                  soft_rst;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  final_beat;
    logic [LEN_WIDTH-1:0]  start_beats;
    logic [TAIL_W-1:0]     start_tail;
    logic [N_ELEM-1:0]     push_mask;
    logic [DATA_WIDTH-1:0] push_data;

    assign soft_rst   = rst_i || clear_i;
    assign fifo_empty = (count == 2'd0);
    assign fifo_full  = (count == 2'd2);

    // Handshakes; the beat limit stops acceptance once the job is fully loaded
    assign in_ready_o  = (state == RUN) && enable_i && !fifo_full
                         && (accepted_beats < total_beats);
    assign out_valid_o = !fifo_empty && enable_i;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Outputs read the FIFO head; an empty FIFO presents all zeros
    assign out_data_o = fifo_empty ? '0 : fifo_data[rd_ptr];
    assign out_mask_o = fifo_empty ? '0 : fifo_mask[rd_ptr];
    assign out_last_o = !fifo_empty && fifo_last[rd_ptr];
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

    // Job geometry from the requested length: beats = ceil(len/N), tail = len mod N
    assign start_tail  = TAIL_W'(length_i % LEN_WIDTH'(N_ELEM));
    assign start_beats = (length_i / LEN_WIDTH'(N_ELEM)) + LEN_WIDTH'(start_tail != '0);

    assign final_beat = (accepted_beats == total_beats - LEN_WIDTH'(1));

    // Lane mask of the incoming beat; a partial final beat keeps only the low tail lanes
    for (genvar g = 0; g < N_ELEM; g++) begin : g_lane
        assign push_mask[g] = !(final_beat && (tail != '0)) || (TAIL_W'(g) < tail);
        assign push_data[g*ELEM_WIDTH +: ELEM_WIDTH] =
            push_mask[g] ? in_data_i[g*ELEM_WIDTH +: ELEM_WIDTH] : '0;
    end

    // Control FSM, beat counter and FIFO update
    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state          <= IDLE;
            total_beats    <= '0;
            accepted_beats <= '0;
            tail           <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= 2'd0;
            fifo_last      <= '0;
            fifo_data[0]   <= '0;
            fifo_data[1]   <= '0;
            fifo_mask[0]   <= '0;
            fifo_mask[1]   <= '0;
        end else if (enable_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        total_beats    <= start_beats;
                        tail           <= start_tail;
                        accepted_beats <= '0;
                        state          <= (length_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Only the final beat carries last, so the FIFO drains with it
                    if (pop && fifo_last[rd_ptr]) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_mask[wr_ptr] <= push_mask;
                fifo_last[wr_ptr] <= final_beat;
                wr_ptr            <= !wr_ptr;
                accepted_beats    <= accepted_beats + LEN_WIDTH'(1);
            end

            if (pop) begin
                rd_ptr <= !rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/softex_stream_tracker.md
SOFTEX_STREAM_TRACKER -- requirements
Module: softex_stream_tracker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: stream data width in bits.
REQ-002 SHALL have parameter ELEM_WIDTH, default 16: element width in bits; N_ELEM = DATA_WIDTH/ELEM_WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 32: width of the element-count field.
REQ-004 SHALL run on one clock with a synchronous, active-high reset.
REQ-005 Port clk_i: input, 1 bit, single clock; all state updates on the rising edge.
REQ-006 Port rst_i: input, 1 bit, synchronous active-high reset.
REQ-007 Port clear_i: input, 1 bit, synchronous soft clear, same effect as rst_i.
REQ-008 Port enable_i: input, 1 bit, when low freezes all state and handshakes.
REQ-009 Port start_i: input, 1 bit, one-cycle job start pulse.
REQ-010 Port length_i: input, LEN_WIDTH bits, job length in elements; sampled on start_i.
REQ-011 Ports in_valid_i (input, 1), in_ready_o (output, 1), in_data_i (input, DATA_WIDTH): upstream load stream from the streamer.
REQ-012 Ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, DATA_WIDTH): downstream stream to the datapath.
REQ-013 Port out_mask_o: output, N_ELEM bits, per-lane valid mask of the current output beat; bit i covers data bits [i*ELEM_WIDTH +: ELEM_WIDTH].
REQ-014 Port out_last_o: output, 1 bit, marks the final beat of the job.
REQ-015 Port busy_o: output, 1 bit, high in any state other than IDLE.
REQ-016 Port done_o: output, 1 bit, one-cycle end-of-job pulse.

Function
REQ-017 SHALL implement the states IDLE, RUN, DONE.
REQ-018 In IDLE, start_i with enable_i high SHALL latch length_i, compute total_beats = ceil(length_i/N_ELEM) and tail = length_i mod N_ELEM, then go to RUN, or to DONE if length_i = 0.
REQ-019 start_i outside IDLE SHALL be ignored.
REQ-020 The block SHALL buffer beats in a 2-entry FIFO.
REQ-021 in_ready_o = (state == RUN) && enable_i && FIFO not full && accepted_beats < total_beats.
REQ-022 A beat SHALL be accepted when in_valid_i && in_ready_o.
REQ-023 Each FIFO entry SHALL store data, mask and last.
REQ-024 mask SHALL be all ones, except on the final beat when tail != 0: then only the low tail bits are set.
REQ-025 Lanes with a mask bit of 0 SHALL be driven to zero in out_data_o.
REQ-026 last SHALL be 1 only when accepted_beats == total_beats-1 at the moment of acceptance.
REQ-027 out_valid_o SHALL equal FIFO not empty && enable_i.
REQ-028 An entry SHALL be popped when out_valid_o && out_ready_i.
REQ-029 Latency SHALL be exactly one cycle: a beat accepted in cycle t is visible on out_* at t+1 when the FIFO was empty.
REQ-030 With FIFO full, a simultaneous push and pop SHALL not be possible, because in_ready_o is low.
REQ-031 With FIFO non-full, a simultaneous push and pop SHALL both occur and keep the occupancy constant.
REQ-032 out_data_o, out_mask_o and out_last_o SHALL stay stable while out_valid_o && !out_ready_i.
REQ-033 The popped entry with last=1 SHALL move RUN to DONE.
REQ-034 DONE SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-035 Input beats arriving in IDLE or DONE, or after the final beat is accepted, SHALL not be acknowledged.
REQ-036 The beat counters SHALL be LEN_WIDTH bits wide, with no wrap-around within a job.
REQ-037 enable_i low SHALL hold state, counters and FIFO contents and force in_ready_o and out_valid_o low.

Reset
REQ-038 On rst_i or clear_i high at a clock edge, the block SHALL reach the following next cycle:
- state IDLE, FIFO empty, counters 0;
- in_ready_o = 0, out_valid_o = 0, out_data_o = 0, out_mask_o = 0;
- out_last_o = 0, busy_o = 0, done_o = 0.
REQ-039 A reset asserted mid-job SHALL abort the job with no done_o pulse.
REQ-040 rst_i SHALL take priority over start_i in the same cycle.

Verification (DATA_WIDTH=64, ELEM_WIDTH=16, N_ELEM=4)
REQ-041 Scenario:
- stimulus: length 10, in_valid_i and out_ready_i always high;
- response: 3 beats, masks 1111/1111/0011, out_last_o on beat 3, lanes 2-3 of beat 3 are zero;
- response: done_o one cycle after the beat-3 pop.
REQ-042 Scenario: length 8 -> 2 beats, masks 1111/1111, last on beat 2, no third in_ready_o.
REQ-043 Scenario: length 0 -> busy_o high one cycle, done_o pulse, in_ready_o never high.
REQ-044 Scenario:
- stimulus: length 16, out_ready_i low for 5 cycles;
- response: exactly 2 beats accepted, then in_ready_o low;
- response: after release, all 4 beats emitted in order with unchanged data.
REQ-045 Scenario: rst_i pulsed after 2 of 4 beats -> all outputs 0 next cycle, no done_o; a new start with length 4 completes normally.
REQ-046 Scenario: enable_i low for 3 cycles mid-job -> no handshakes occur, and the job resumes with an identical beat sequence.
